// File: rtl/fx_div_seq.sv
// fx_div_seq: sequential signed Q(P).(F) divider, radix-2 restoring, one step per clock, saturating.
// Optional macro FXDIV_ROUND_EN: one extra quotient bit, magnitude rounded half-up before saturation.
module fx_div_seq #(
  parameter  int F = 10,
  parameter  int P = 5,
  localparam int W = F + P + 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  output logic [W-1:0] Y,
  output logic         done,
  output logic         busy,
  output logic         ovf,
  output logic         dbz
);

  localparam int N  = W + F;
`ifdef FXDIV_ROUND_EN
  localparam int NI = N + 1;
`else
  localparam int NI = N;
`endif
  localparam int QW = N + 1;
  localparam int DS = NI - W;
  localparam int CW = $clog2(NI + 1);

  localparam logic [W-1:0]  MAX_Y  = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0]  MIN_Y  = {1'b1, {(W-1){1'b0}}};
  localparam logic [QW-1:0] HALF_Q = {{(QW-W){1'b0}}, 1'b1, {(W-1){1'b0}}};
  localparam logic [QW-1:0] MAXP_Q = {{(QW-W+1){1'b0}}, {(W-1){1'b1}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t          state_r, state_s;
  logic            accept_s, last_s;
  logic [NI-1:0]   dvd_r;
  logic [NI-1:0]   qa_r;
  logic [W-1:0]    rem_r;
  logic [W-1:0]    bm_r;
  logic [CW-1:0]   cnt_r;
  logic            sign_r, a_neg_r, a_zero_r, b_zero_r;
  logic [W:0]      shl_s;
  logic            ge_s;
  logic [W-1:0]    rem_nxt_s;
  logic [QW-1:0]   q_s;
  logic [W-1:0]    y_s;
  logic            ovf_s;
  logic [W-1:0]    y_r;
  logic            done_r, busy_r, ovf_r, dbz_r;

  // Two's-complement magnitude as unsigned W bits, so the most negative value maps exactly.
  function automatic logic [W-1:0] mag_f(input logic [W-1:0] v);
    mag_f = v[W-1] ? (~v + {{(W-1){1'b0}}, 1'b1}) : v;
  endfunction

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic and accept decode.
  always_comb begin
    state_s  = state_r;
    accept_s = 1'b0;
    last_s   = (cnt_r == CW'(NI - 1));
    case (state_r)
      S_IDLE: begin
        if (start) begin
          state_s  = S_CALC;
          accept_s = 1'b1;
        end else begin
          state_s  = S_IDLE;
        end
      end
      S_CALC: begin
        if (last_s) begin
          state_s = S_FIX;
        end else begin
          state_s = S_CALC;
        end
      end
      S_FIX:   state_s = S_IDLE;
      default: state_s = S_IDLE;
    endcase
  end

  // One restoring step: shift in the next dividend bit, subtract when the divisor fits.
  always_comb begin
    shl_s = {rem_r, dvd_r[NI-1]};
    ge_s  = (shl_s >= {1'b0, bm_r});
    if (ge_s) begin
      rem_nxt_s = shl_s[W-1:0] - bm_r;
    end else begin
      rem_nxt_s = shl_s[W-1:0];
    end
  end

  // Iteration datapath: operand capture on accept, shift/subtract while calculating.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dvd_r    <= '0;
      qa_r     <= '0;
      rem_r    <= '0;
      bm_r     <= '0;
      cnt_r    <= '0;
      sign_r   <= 1'b0;
      a_neg_r  <= 1'b0;
      a_zero_r <= 1'b0;
      b_zero_r <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (start) begin
            dvd_r    <= {mag_f(A), {DS{1'b0}}};
            qa_r     <= '0;
            rem_r    <= '0;
            bm_r     <= mag_f(B);
            cnt_r    <= '0;
            sign_r   <= A[W-1] ^ B[W-1];
            a_neg_r  <= A[W-1];
            a_zero_r <= (A == {W{1'b0}});
            b_zero_r <= (B == {W{1'b0}});
          end
        end
        S_CALC: begin
          dvd_r <= {dvd_r[NI-2:0], 1'b0};
          qa_r  <= {qa_r[NI-2:0], ge_s};
          rem_r <= rem_nxt_s;
          cnt_r <= cnt_r + CW'(1);
        end
        default: begin
          cnt_r <= cnt_r;
        end
      endcase
    end
  end

  // Quotient magnitude, optionally rounded half-up from the extra fraction bit.
  always_comb begin
`ifdef FXDIV_ROUND_EN
    q_s = {1'b0, qa_r[NI-1:1]} + {{(QW-1){1'b0}}, qa_r[0]};
`else
    q_s = {1'b0, qa_r};
`endif
  end

  // Sign correction, saturation and divide-by-zero override.
  always_comb begin
    y_s   = '0;
    ovf_s = 1'b0;
    if (b_zero_r) begin
      if (a_zero_r) begin
        y_s   = '0;
        ovf_s = 1'b0;
      end else if (a_neg_r) begin
        y_s   = MIN_Y;
        ovf_s = 1'b1;
      end else begin
        y_s   = MAX_Y;
        ovf_s = 1'b1;
      end
    end else if (sign_r) begin
      if (q_s > HALF_Q) begin
        y_s   = MIN_Y;
        ovf_s = 1'b1;
      end else if (q_s == HALF_Q) begin
        y_s   = MIN_Y;
        ovf_s = 1'b0;
      end else begin
        y_s   = ~q_s[W-1:0] + {{(W-1){1'b0}}, 1'b1};
        ovf_s = 1'b0;
      end
    end else begin
      if (q_s > MAXP_Q) begin
        y_s   = MAX_Y;
        ovf_s = 1'b1;
      end else begin
        y_s   = q_s[W-1:0];
        ovf_s = 1'b0;
      end
    end
  end

  // Registered handshake and result; flags clear on accept, load in FIX.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_r    <= '0;
      done_r <= 1'b0;
      busy_r <= 1'b0;
      ovf_r  <= 1'b0;
      dbz_r  <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (accept_s) begin
        busy_r <= 1'b1;
        ovf_r  <= 1'b0;
        dbz_r  <= 1'b0;
      end else if (state_r == S_FIX) begin
        busy_r <= 1'b0;
        done_r <= 1'b1;
        y_r    <= y_s;
        ovf_r  <= ovf_s;
        dbz_r  <= b_zero_r;
      end else begin
        busy_r <= busy_r;
      end
    end
  end

  assign Y    = y_r;
  assign done = done_r;
  assign busy = busy_r;
  assign ovf  = ovf_r;
  assign dbz  = dbz_r;

endmodule

// File: tb/tb_fx_div_seq.sv
// Self-checking bench for fx_div_seq: directed plan vectors, handshake corners and random
// operands against an integer-arithmetic reference model.
module tb_fx_div_seq;

  localparam int F = 10;
  localparam int P = 5;
  localparam int W = F + P + 1;
  localparam int N = W + F;
`ifdef FXDIV_ROUND_EN
  localparam int LAT = N + 2;
  localparam logic [W-1:0] Y_TWO_THIRDS = 16'h02AB;
`else
  localparam int LAT = N + 1;
  localparam logic [W-1:0] Y_TWO_THIRDS = 16'h02AA;
`endif

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a_in  = '0;
  logic [W-1:0] b_in  = '0;
  logic [W-1:0] y;
  logic         done, busy, ovf, dbz;

  int checks = 0;
  int errors = 0;

  fx_div_seq #(.F(F), .P(P)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .A    (a_in),
    .B    (b_in),
    .Y    (y),
    .done (done),
    .busy (busy),
    .ovf  (ovf),
    .dbz  (dbz)
  );

  always #5 clk = ~clk;

  // Reference: real-valued division of the fixed-point numbers, done on scaled integers.
  function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] ey, output logic eovf, output logic edbz);
    longint sa, sb, ma, mb, q;
    logic [63:0] t;
    sa   = longint'($signed(a));
    sb   = longint'($signed(b));
    eovf = 1'b0;
    edbz = (sb == 0);
    ey   = '0;
    if (sb == 0) begin
      if (sa > 0) begin ey = 16'h7FFF; eovf = 1'b1; end
      else if (sa < 0) begin ey = 16'h8000; eovf = 1'b1; end
      else ey = 16'h0000;
    end else begin
      ma = (sa < 0) ? -sa : sa;
      mb = (sb < 0) ? -sb : sb;
`ifdef FXDIV_ROUND_EN
      q = ((ma * 2048) / mb + 1) / 2;
`else
      q = (ma * 1024) / mb;
`endif
      if ((sa < 0) != (sb < 0)) begin
        if (q > 32768) begin ey = 16'h8000; eovf = 1'b1; end
        else begin t = 64'(-q); ey = t[W-1:0]; end
      end else begin
        if (q > 32767) begin ey = 16'h7FFF; eovf = 1'b1; end
        else begin t = 64'(q); ey = t[W-1:0]; end
      end
    end
  endfunction

  // Issue one operation and return the number of edges from accept to done (-1 on timeout).
  // Operand inputs are scrambled while busy; they must not affect the result.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, output int lat);
    @(negedge clk);
    a_in  = a;
    b_in  = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat   = -1;
    for (int c = 0; c <= 200; c++) begin
      @(negedge clk);
      if (done) begin
        lat = c;
        break;
      end
      a_in = W'($urandom);
      b_in = W'($urandom);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (y !== 16'h0000 || done !== 1'b0 || busy !== 1'b0 || ovf !== 1'b0 || dbz !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got y=%h done=%b busy=%b ovf=%b dbz=%b, want all zero",
               y, done, busy, ovf, dbz);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: got busy=%b done=%b, want 0 0", busy, done);
    end
  endtask

  logic [W-1:0] dir_a   [9] = '{16'h0C00, 16'hFC00, 16'h8000, 16'h7FFF, 16'h8000,
                                16'h0400, 16'hFC00, 16'h0000, 16'h0800};
  logic [W-1:0] dir_b   [9] = '{16'h0800, 16'h0200, 16'h0400, 16'h0001, 16'hFC00,
                                16'h0000, 16'h0000, 16'h0000, 16'h0C00};
  logic [W-1:0] dir_y   [9] = '{16'h0600, 16'hF800, 16'h8000, 16'h7FFF, 16'h7FFF,
                                16'h7FFF, 16'h8000, 16'h0000, 16'h0000};
  logic         dir_ovf [9] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
  logic         dir_dbz [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

  task automatic test_directed();
    int lat;
    logic [W-1:0] ey;
    for (int i = 0; i < 9; i++) begin
      run_op(dir_a[i], dir_b[i], lat);
      ey = (i == 8) ? Y_TWO_THIRDS : dir_y[i];
      checks++;
      if (lat !== LAT) begin
        errors++;
        $display("FAIL dir%0d_latency: got %0d, want %0d", i, lat, LAT);
      end
      checks++;
      if (y !== ey || ovf !== dir_ovf[i] || dbz !== dir_dbz[i]) begin
        errors++;
        $display("FAIL dir%0d_result A=%h B=%h: got y=%h ovf=%b dbz=%b, want y=%h ovf=%b dbz=%b",
                 i, dir_a[i], dir_b[i], y, ovf, dbz, ey, dir_ovf[i], dir_dbz[i]);
      end
    end
  endtask

  task automatic test_random();
    int lat;
    logic [W-1:0] a, b, ey;
    logic eovf, edbz;
    for (int i = 0; i < 40; i++) begin
      a = W'($urandom);
      b = W'($urandom);
      case (i % 8)
        0: b = '0;
        1: b = W'($urandom_range(1, 15));
        2: b = -W'($urandom_range(1, 15));
        3: a = 16'h8000;
        4: a = '0;
        default: b = b;
      endcase
      ref_div(a, b, ey, eovf, edbz);
      run_op(a, b, lat);
      checks++;
      if (lat !== LAT) begin
        errors++;
        $display("FAIL rnd%0d_latency: got %0d, want %0d", i, lat, LAT);
      end
      checks++;
      if (y !== ey || ovf !== eovf || dbz !== edbz) begin
        errors++;
        $display("FAIL rnd%0d_result A=%h B=%h: got y=%h ovf=%b dbz=%b, want y=%h ovf=%b dbz=%b",
                 i, a, b, y, ovf, dbz, ey, eovf, edbz);
      end
    end
  endtask

  task automatic test_start_while_busy();
    int lat;
    int extra;
    @(negedge clk);
    a_in = 16'hFC00; b_in = 16'h0200; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat = -1;
    for (int c = 0; c <= 200; c++) begin
      @(negedge clk);
      if (done) begin
        lat = c;
        break;
      end
      if (c == 10) begin
        checks++;
        if (busy !== 1'b1) begin
          errors++;
          $display("FAIL busy_mid_calc: got %b, want 1", busy);
        end
        a_in = 16'h7FFF; b_in = 16'h0001; start = 1'b1;
      end else begin
        start = 1'b0;
      end
    end
    checks++;
    if (lat !== LAT || y !== 16'hF800 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL ignore_start: got lat=%0d y=%h ovf=%b, want lat=%0d y=f800 ovf=0",
               lat, y, ovf, LAT);
    end
    extra = 0;
    repeat (5) begin
      @(negedge clk);
      if (busy || done) extra++;
    end
    checks++;
    if (extra !== 0) begin
      errors++;
      $display("FAIL no_second_op: got %0d busy/done cycles, want 0", extra);
    end
  endtask

  task automatic test_back_to_back();
    int lat1, gap;
    @(negedge clk);
    a_in = 16'h0C00; b_in = 16'h0800; start = 1'b1;
    @(posedge clk);
    #1;
    lat1 = -1;
    for (int c = 0; c <= 200; c++) begin
      @(negedge clk);
      if (done) begin
        lat1 = c;
        break;
      end
    end
    checks++;
    if (lat1 !== LAT || y !== 16'h0600) begin
      errors++;
      $display("FAIL b2b_first: got lat=%0d y=%h, want lat=%0d y=0600", lat1, y, LAT);
    end
    a_in = 16'h0800; b_in = 16'h0C00;
    gap = -1;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      if (c == 1) begin
        checks++;
        if (busy !== 1'b1) begin
          errors++;
          $display("FAIL b2b_accept: got busy=%b, want 1", busy);
        end
        start = 1'b0;
      end
      if (done) begin
        gap = c;
        break;
      end
    end
    // Second accept happens on the edge after the first done, then LAT more edges.
    checks++;
    if (gap !== LAT + 1 || y !== Y_TWO_THIRDS) begin
      errors++;
      $display("FAIL b2b_second: got gap=%0d y=%h, want gap=%0d y=%h",
               gap, y, LAT + 1, Y_TWO_THIRDS);
    end
    start = 1'b0;
  endtask

  task automatic test_reset_mid();
    int lat;
    int seen;
    run_op(16'h0400, 16'h0000, lat);
    @(negedge clk);
    a_in = 16'h0C00; b_in = 16'h0800; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (y !== 16'h0000 || done !== 1'b0 || busy !== 1'b0 || ovf !== 1'b0 || dbz !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_outputs: got y=%h done=%b busy=%b ovf=%b dbz=%b, want all zero",
               y, done, busy, ovf, dbz);
    end
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (c == 2) rst_n = 1'b1;
      if (done || busy) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL reset_mid_abort: got %0d busy/done cycles, want 0", seen);
    end
    run_op(16'h0800, 16'h0C00, lat);
    checks++;
    if (lat !== LAT || y !== Y_TWO_THIRDS || ovf !== 1'b0 || dbz !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_recover: got lat=%0d y=%h ovf=%b dbz=%b, want lat=%0d y=%h ovf=0 dbz=0",
               lat, y, ovf, dbz, LAT, Y_TWO_THIRDS);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
